icache: RTL and testbench
=========================

// Module: icache
// PURPOSE
//  Direct-mapped, one-word-per-frame, read-only instruction cache feeding the datapath IF stage.
//  Serves the datapath fetch port (imemREN/imemaddr -> ihit/imemload) and refills from the memory
//  controller on a miss. ihit is the fetch-complete strobe that gates PC update and pipeline advance.
//  Keeps hit/miss statistics for performance runs.
// PARAMETERS
//  NSETS  16  number of frames; power of two >= 2; IDX_W = $clog2(NSETS)
//  CNT_W  32  width of hit/miss statistic counters
// PORTS
//  CLK         in   1       clock, all state updates on rising edge
//  nRST        in   1       asynchronous, active-low reset
//  imemREN     in   1       datapath fetch request; low while halted
//  imemaddr    in   32      fetch byte address; [1:0] ignored
//  ihit        out  1       fetch data valid this cycle
//  imemload    out  32      instruction word; 0 when ihit low
//  iREN        out  1       memory read request
//  iaddr       out  32      memory read address, word aligned ([1:0]=0)
//  iwait       in   1       memory busy; iload valid in a cycle where iREN=1 and iwait=0
//  iload       in   32      memory read data
//  hit_count   out  CNT_W   number of fetches served as hits
//  miss_count  out  CNT_W   number of misses started
// BEHAVIOUR
//  Address split: offset [1:0], index [IDX_W+1:2], tag [31:IDX_W+2]. Frame = {valid, tag, data}.
//  Reset (async, any state): all valid=0, state=IDLE, iREN=0, iaddr=0, ihit=0, imemload=0,
//   counters=0. Tag/data arrays need not reset.
//  Hit: imemREN & valid[idx] & tag match -> ihit=1, imemload=data[idx] combinationally, same cycle
//   (zero-latency hit). hit_count += 1 on that edge.
//  FSM states IDLE, FETCH.
//   IDLE: on imemREN & ~hit -> latch miss_addr = {imemaddr[31:2],2'b00}, miss_count += 1,
//    go FETCH. imemREN low -> stay IDLE, ihit=0, no memory traffic.
//   FETCH: iREN=1, iaddr=miss_addr; ihit=0 throughout. While iwait=1 stay. When iwait=0: write
//    frame[miss_addr idx] = {1, miss_addr tag, iload}, go IDLE. No bypass: the instruction is
//    returned as a hit in the following cycle (miss penalty = memory latency + 1 cycle).
//  Lookup in FETCH is suppressed; the latched miss_addr, not imemaddr, is used for the fill.
//  imemREN dropping or imemaddr changing during FETCH: transaction still completes and fills;
//   the new address is looked up normally from IDLE afterwards.
//  Conflict: fill overwrites the indexed frame unconditionally (eviction, no write-back).
//  Counters saturate at all-ones (no wrap). Counters only increment in the cases above.
//  iREN never asserted in IDLE; iaddr holds last miss_addr while iREN=0.
//  Read-only: no write path, no coherence, no flush port; reset is the only invalidation.
// TESTING
//  1 Cold miss: reset, imemREN=1, imemaddr=0x0000_0004, memory latency 3, iload=0x2001_0005 ->
//    iREN=1/iaddr=0x4 for 3 cycles, next cycle ihit=1 imemload=0x2001_0005, miss=1 hit=1.
//  2 Hit streak: after filling 0x0..0x3C, re-fetch all 16 -> ihit every cycle, iREN=0, hit_count+=16.
//  3 Conflict: fill 0x0040 then fetch 0x0000 (same index, tag differs) -> miss, refill, then
//    0x0040 misses again; miss_count increments each time.
//  4 Reset mid-FETCH: deassert nRST while iwait=1 -> iREN drops immediately, ihit=0, counters 0;
//    re-fetch of any earlier-filled address misses.
//  5 imemREN low (halt) during FETCH at 0x0008 -> fill completes, iREN drops; later fetch 0x0008
//    with imemREN=1 hits with no memory request.
//  6 Saturation: CNT_W=4, 20 hits -> hit_count holds 4'hF; byte offset 0x0006 hits word 0x0004.

Source files
------------

// File: rtl/icache.sv
// icache: direct-mapped, one-word-per-frame read-only instruction cache with zero-latency hits
// and saturating hit/miss statistics.
module icache #(
    parameter int NSETS = 16,
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             imemREN,
    input  logic [31:0]      imemaddr,
    output logic             ihit,
    output logic [31:0]      imemload,
    output logic             iREN,
    output logic [31:0]      iaddr,
    input  logic             iwait,
    input  logic [31:0]      iload,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] miss_count
);
    localparam int IDX_W = $clog2(NSETS);
    localparam int TAG_W = 30 - IDX_W;
    localparam logic IDLE = 1'b0;
    localparam logic FETCH = 1'b1;

    logic             state_q, state_d;
    logic [31:0]      miss_addr_q, miss_addr_d;
    logic [NSETS-1:0] valid_q, valid_d;
    logic [CNT_W-1:0] hit_q, hit_d, miss_q, miss_d;
    logic [TAG_W-1:0] tag_q [NSETS];
    logic [31:0]      data_q [NSETS];
    logic [IDX_W-1:0] idx, fidx;
    logic             hit, fill, unused_ok;

    assign idx = imemaddr[IDX_W+1:2];
    assign fidx = miss_addr_q[IDX_W+1:2];
    // Lookup is suppressed while a refill is outstanding
    assign hit = imemREN && state_q == IDLE && valid_q[idx] && tag_q[idx] == imemaddr[31:IDX_W+2];
    assign fill = state_q == FETCH && !iwait;
    assign ihit = hit;
    assign imemload = hit ? data_q[idx] : '0;
    assign iREN = state_q == FETCH;
    assign iaddr = miss_addr_q;
    assign hit_count = hit_q;
    assign miss_count = miss_q;
    assign unused_ok = ^imemaddr[1:0];

    always_comb begin
        state_d = state_q;
        miss_addr_d = miss_addr_q;
        valid_d = valid_q;
        hit_d = hit_q;
        miss_d = miss_q;
        if (hit) hit_d = hit_q + {{(CNT_W-1){1'b0}}, ~&hit_q};
        if (state_q == IDLE && imemREN && !hit) begin
            state_d = FETCH;
            miss_addr_d = {imemaddr[31:2], 2'b00};
            miss_d = miss_q + {{(CNT_W-1){1'b0}}, ~&miss_q};
        end
        if (fill) begin
            state_d = IDLE;
            valid_d[fidx] = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            miss_addr_q <= '0;
            valid_q <= '0;
            hit_q <= '0;
            miss_q <= '0;
        end else begin
            state_q <= state_d;
            miss_addr_q <= miss_addr_d;
            valid_q <= valid_d;
            hit_q <= hit_d;
            miss_q <= miss_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (fill) begin
            tag_q[fidx] <= miss_addr_q[31:IDX_W+2];
            data_q[fidx] <= iload;
        end
    end
endmodule

// File: tb/tb_icache.sv
// tb_icache: directed vectors for icache; a 4-bit-counter instance shares the stimulus
// to exercise counter saturation.
module tb_icache;
    logic        CLK = 1'b0, nRST = 1'b0, imemREN = 1'b0, iwait = 1'b1;
    logic [31:0] imemaddr = '0, iload = '0;
    logic        ihit, iREN, ihit4, iREN4;
    logic [31:0] imemload, iaddr, imemload4, iaddr4, hit_count, miss_count;
    logic [3:0]  hit4, miss4;
    int          vectors = 0, miscompares = 0;
    int          exp_hit = 0, exp_miss = 0;

    icache dut (
        .CLK(CLK), .nRST(nRST), .imemREN(imemREN), .imemaddr(imemaddr),
        .ihit(ihit), .imemload(imemload), .iREN(iREN), .iaddr(iaddr),
        .iwait(iwait), .iload(iload), .hit_count(hit_count), .miss_count(miss_count)
    );

    icache #(.CNT_W(4)) dut4 (
        .CLK(CLK), .nRST(nRST), .imemREN(imemREN), .imemaddr(imemaddr),
        .ihit(ihit4), .imemload(imemload4), .iREN(iREN4), .iaddr(iaddr4),
        .iwait(iwait), .iload(iload), .hit_count(hit4), .miss_count(miss4)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_counts(input string tag);
        check({tag, " hit_count"}, hit_count, exp_hit);
        check({tag, " miss_count"}, miss_count, exp_miss);
    endtask

    function automatic logic [31:0] dat(input logic [31:0] a);
        return 32'h1000_0000 | a;
    endfunction

    // Miss on addr, memory answers on the lat-th FETCH cycle; ends after the fill edge.
    task automatic miss_fetch(input logic [31:0] a, input int lat, input logic [31:0] d);
        imemREN = 1'b1;
        imemaddr = a;
        iwait = 1'b1;
        #1;
        check("miss ihit", {31'b0, ihit}, 0);
        check("miss iREN idle", {31'b0, iREN}, 0);
        step();
        exp_miss++;
        for (int i = 0; i < lat; i++) begin
            iwait = (i < lat - 1);
            iload = d;
            #1;
            check("fetch iREN", {31'b0, iREN}, 1);
            check("fetch iaddr", iaddr, {a[31:2], 2'b00});
            check("fetch ihit", {31'b0, ihit}, 0);
            step();
        end
        iwait = 1'b1;
        iload = '0;
    endtask

    task automatic hit_fetch(input logic [31:0] a, input logic [31:0] d);
        imemREN = 1'b1;
        imemaddr = a;
        #1;
        check("hit ihit", {31'b0, ihit}, 1);
        check("hit imemload", imemload, d);
        check("hit iREN", {31'b0, iREN}, 0);
        step();
        exp_hit++;
    endtask

    initial begin
        #12;
        check("rst ihit", {31'b0, ihit}, 0);
        check("rst imemload", imemload, 0);
        check("rst iREN", {31'b0, iREN}, 0);
        check("rst iaddr", iaddr, 0);
        check_counts("rst");
        nRST = 1'b1;
        step();

        // cold miss
        miss_fetch(32'h4, 3, 32'h2001_0005);
        hit_fetch(32'h4, 32'h2001_0005);
        check_counts("cold");

        // fill 0x00..0x3C, then a continuous hit streak
        for (int i = 0; i < 16; i++)
            if (i != 1) miss_fetch(i * 4, 1, dat(i * 4));
        check_counts("fill");
        for (int i = 0; i < 16; i++)
            hit_fetch(i * 4, (i == 1) ? 32'h2001_0005 : dat(i * 4));
        check_counts("streak");

        // conflict on index 0
        miss_fetch(32'h40, 2, 32'hC0DE_0040);
        hit_fetch(32'h40, 32'hC0DE_0040);
        miss_fetch(32'h0, 2, dat(0));
        hit_fetch(32'h0, dat(0));
        miss_fetch(32'h40, 1, 32'hC0DE_0040);
        check_counts("conflict");

        // halt during FETCH at 0x8 (evict index 2 first)
        miss_fetch(32'h48, 1, dat(32'h48));
        imemaddr = 32'h8;
        #1;
        check("halt miss ihit", {31'b0, ihit}, 0);
        step();
        exp_miss++;
        imemREN = 1'b0;
        imemaddr = 32'h100;
        #1;
        check("halt iREN", {31'b0, iREN}, 1);
        check("halt iaddr", iaddr, 32'h8);
        step();
        iwait = 1'b0;
        iload = 32'h0BAD_0008;
        step();
        iwait = 1'b1;
        check("halt done iREN", {31'b0, iREN}, 0);
        check("halt done ihit", {31'b0, ihit}, 0);
        check("halt iaddr hold", iaddr, 32'h8);
        step();
        check("halt idle iREN", {31'b0, iREN}, 0);
        hit_fetch(32'h8, 32'h0BAD_0008);
        check_counts("halt");

        // reset in the middle of a refill
        imemREN = 1'b1;
        imemaddr = 32'h0;
        step();
        check("pre-rst iREN", {31'b0, iREN}, 1);
        nRST = 1'b0;
        #1;
        exp_hit = 0;
        exp_miss = 0;
        check("midrst iREN", {31'b0, iREN}, 0);
        check("midrst iaddr", iaddr, 0);
        check("midrst ihit", {31'b0, ihit}, 0);
        check_counts("midrst");
        step();
        nRST = 1'b1;
        miss_fetch(32'h3C, 1, dat(32'h3C));
        check_counts("post-rst");

        // saturation of the 4-bit instance; byte offset ignored
        miss_fetch(32'h4, 1, 32'h2001_0005);
        for (int i = 0; i < 20; i++) hit_fetch(32'h6, 32'h2001_0005);
        check_counts("sat");
        check("sat hit4", {28'b0, hit4}, 32'hF);
        check("sat miss4", {28'b0, miss4}, 2);
        check("sat ihit4", {31'b0, ihit4}, 1);
        imemREN = 1'b0;
        step();
        check("sat idle ihit", {31'b0, ihit}, 0);
        check("sat hold", hit_count, 20);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
